// File: rtl/tb_mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1; payload is held while valid=1 and ready=0.
interface tb_mem_responder_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tb_mem_responder.sv
// Target-side responder: executes read/write requests against a word memory and
// returns one in-order response per request through a registered response FIFO.
module tb_mem_responder #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 64,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    tb_mem_responder_if.slave bus
);
    localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(MEM_WORDS);
    localparam logic [PW-1:0] LAST_PTR   = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(RSP_DEPTH);

    logic [DW-1:0] mem        [MEM_WORDS];
    logic [DW-1:0] fifo_rdata [RSP_DEPTH];
    logic          fifo_err   [RSP_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rst_n_q;

    logic          accept;
    logic          pop;
    logic          in_range;
    logic [IW-1:0] word_idx;
    logic [DW-1:0] push_rdata;
    logic          push_err;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign in_range = ({1'b0, bus.req_addr} < ADDR_LIMIT);
    assign word_idx = bus.req_addr[IW-1:0];

    // Readiness uses registered state only, so a same-cycle pop never frees a slot.
    assign bus.req_ready = rst_n_q && (count < FULL_CNT);
    assign bus.rsp_valid = rst_n_q && (count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? fifo_rdata[rd_ptr] : '0;
    assign bus.rsp_err   = bus.rsp_valid ? fifo_err[rd_ptr]   : 1'b0;

    assign accept = bus.req_valid && bus.req_ready;
    assign pop    = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        push_rdata = '0;
        push_err   = 1'b0;
        if (!in_range) begin
            push_err = 1'b1;
        end else if (!bus.req_we) begin
            push_rdata = mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        rst_n_q <= rst_n;
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= next_ptr(wr_ptr);
            if (pop)    rd_ptr <= next_ptr(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && bus.req_we && in_range) begin
            mem[word_idx] <= bus.req_wdata;
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= push_err;
        end
    end
endmodule

// File: tb/tb_tb_mem_responder.sv
// Self-checking bench for tb_mem_responder: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tb_mem_responder;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MEM_WORDS = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tb_mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  tb_mem_responder #(
    .AW(AW), .DW(DW), .MEM_WORDS(MEM_WORDS), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   act_log[$];
  logic [DW-1:0] model_mem [MEM_WORDS];
  logic          armed = 1'b0;
  logic          rst_prev = 1'b0;
  logic          exp_ready;
  logic          exp_valid;
  logic [DW:0]   head;
  logic          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding responses are a queue, memory is an array.
  always @(negedge clk) begin
    exp_ready = rst_prev && (exp_q.size() < DEPTH);
    exp_valid = rst_prev && (exp_q.size() != 0);
    head = exp_valid ? exp_q[0] : '0;
    if (armed) begin
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
      check("rsp_rdata", 64'(bus.rsp_rdata), 64'(head[DW-1:0]));
      check("rsp_err",   64'(bus.rsp_err),   64'(head[DW]));
    end
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
      armed = 1'b1;
    end else if (armed) begin
      if (exp_valid && bus.rsp_ready) begin
        act_log.push_back({bus.rsp_err, bus.rsp_rdata});
        void'(exp_q.pop_front());
      end
      if (bus.req_valid && exp_ready) begin
        if (int'(bus.req_addr) >= MEM_WORDS) begin
          exp_q.push_back({1'b1, {DW{1'b0}}});
        end else if (bus.req_we) begin
          model_mem[int'(bus.req_addr)] = bus.req_wdata;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back({1'b0, model_mem[int'(bus.req_addr)]});
        end
      end
    end
    rst_prev = rst_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = bus.req_ready;
      step();
      n++;
    end
    if (!ok) check("req_timeout", 64'(ok), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n_acc;
    int n;
    logic [AW-1:0] waddr [10];
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(bus.req_ready), 64'd0);
    check("post_reset_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("ready_rises", 64'(bus.req_ready), 64'd1);

    // Read of fresh memory, response one cycle after accept
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 8'd5, '0);
    @(negedge clk);
    check("t1_latency_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("t1_err", 64'(bus.rsp_err), 64'd0);
    drain();

    // Write then read back
    act_log.delete();
    do_req(1'b1, 8'd3, 32'hDEADBEEF);
    do_req(1'b0, 8'd3, '0);
    drain();
    check("t2_count", 64'(act_log.size()), 64'd2);
    check("t2_wr_rsp", 64'(act_log[0]), 64'd0);
    check("t2_rd_rsp", 64'(act_log[1]), {31'd0, 1'b0, 32'hDEADBEEF});

    // Out-of-range accesses do not touch memory
    act_log.delete();
    do_req(1'b1, 8'd64, 32'h5555_5555);
    do_req(1'b0, 8'd64, '0);
    do_req(1'b0, 8'd255, '0);
    for (int a = 0; a < MEM_WORDS; a++) do_req(1'b0, AW'(a), '0);
    drain();
    check("t3_wr64_err", 64'(act_log[0]), {31'd0, 1'b1, 32'd0});
    check("t3_rd64_err", 64'(act_log[1]), {31'd0, 1'b1, 32'd0});
    check("t3_rd255_err", 64'(act_log[2]), {31'd0, 1'b1, 32'd0});
    check("t3_addr0", 64'(act_log[3]), 64'd0);
    check("t3_addr3", 64'(act_log[6]), {31'd0, 1'b0, 32'hDEADBEEF});

    // Six back-to-back reads against a stalled response port
    for (int i = 0; i < 6; i++) do_req(1'b1, AW'(10 + i), DW'(32'h100 + i));
    drain();
    act_log.delete();
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 8'd10;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_ready) n_acc++;
      step();
      bus.req_addr = AW'(10 + n_acc);
    end
    check("t4_accepted_full", 64'(n_acc), 64'd4);
    @(negedge clk);
    check("t4_ready_full", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (n_acc < 6 && n < 40) begin
      @(negedge clk);
      if (bus.req_ready) n_acc++;
      step();
      bus.req_addr = AW'(10 + n_acc);
      n++;
    end
    bus.req_valid = 1'b0;
    check("t4_accepted_all", 64'(n_acc), 64'd6);
    drain();
    check("t4_rsp_count", 64'(act_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) check("t4_order", 64'(act_log[i]), 64'(32'h100 + i));

    // Full FIFO: pop and request in the same cycle, accept only on the next
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_req(1'b0, AW'(i), '0);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 8'd20;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_no_accept_when_full", 64'(bus.req_ready), 64'd0);
    step();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("t5_ready_after_pop", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 1'b0;
    drain();

    // Writes with random stalls, then reset with responses outstanding
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waddr[i] = AW'($urandom_range(0, MEM_WORDS - 1));
      do_req(1'b1, waddr[i], $urandom | 32'h1);
    end
    rand_rdy = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", 64'(bus.rsp_valid), 64'd0);
    check("t6_ready_after_rst", 64'(bus.req_ready), 64'd0);
    step();
    act_log.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) do_req(1'b0, waddr[i], '0);
    drain();
    check("t6_rsp_count", 64'(act_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) check("t6_cleared", 64'(act_log[i]), 64'd0);

    // Randomized mixed traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(MEM_WORDS, 255));
      else a = AW'($urandom_range(0, MEM_WORDS - 1));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
